// File: rtl/ctu_cluster_rst_seq.sv
// ctu_cluster_rst_seq
//
// Clock-control-side reset sequencer for the CPU cluster headers.
//
// On a cold start it enables the cluster clocks one slot at a time, then
// holds the global reset low for a while before releasing it. Once in RUN
// it services warm-reset and debug-init requests through req/ack handshakes.
//
// Optional build macro CTU_RST_SEQ_SCAN_EN adds a scan-enable input `se`.
// While se is high, all cluster clocks are forced on, the sequencer state
// and counters freeze, and the acks are held low.
//
// Ports
//   gclk          in   global clock; all state changes on the rising edge
//   arst_l        in   asynchronous active-low reset
//   por_done      in   power-on complete; level, synchronous to gclk
//   cken_mask     in   per-cluster permission to clock (quasi-static)
//   warm_rst_req  in   warm reset request; level, held until acked
//   dbg_init_req  in   debug init request; level, held until acked
//   se            in   scan enable (only with CTU_RST_SEQ_SCAN_EN)
//   cluster_cken  out  per-cluster clock enable
//   grst_l        out  global sync reset to the clusters, active low
//   gdbginit_l    out  global debug init to the clusters, active low
//   warm_rst_ack  out  1-cycle pulse when a warm request is accepted
//   dbg_init_ack  out  1-cycle pulse when a debug request is accepted
//   rst_done      out  1-cycle pulse on every grst_l rising edge
//   seq_busy      out  high in every state except RUN
module ctu_cluster_rst_seq #(
    parameter int NUM_CLUSTERS = 4,
    parameter int CKEN_STAGGER = 2,
    parameter int RST_HOLD     = 16,
    parameter int DBG_HOLD     = 8
) (
    input  logic                    gclk,
    input  logic                    arst_l,
    input  logic                    por_done,
    input  logic [NUM_CLUSTERS-1:0] cken_mask,
    input  logic                    warm_rst_req,
    input  logic                    dbg_init_req,
`ifdef CTU_RST_SEQ_SCAN_EN
    input  logic                    se,
`endif
    output logic [NUM_CLUSTERS-1:0] cluster_cken,
    output logic                    grst_l,
    output logic                    gdbginit_l,
    output logic                    warm_rst_ack,
    output logic                    dbg_init_ack,
    output logic                    rst_done,
    output logic                    seq_busy
);

    localparam int MAX_A = (RST_HOLD > DBG_HOLD) ? RST_HOLD : DBG_HOLD;
    localparam int MAX_V = (MAX_A > CKEN_STAGGER) ? MAX_A : CKEN_STAGGER;
    localparam int CW    = $clog2(MAX_V + 1);
    localparam int SW    = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    localparam logic [CW-1:0] STAG_LAST = CW'(CKEN_STAGGER - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DBG_LAST  = CW'(DBG_HOLD - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CLUSTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CKEN_ON = 3'd1,
        S_RST_HLD = 3'd2,
        S_RUN     = 3'd3,
        S_WARM    = 3'd4,
        S_DBG     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [NUM_CLUSTERS-1:0] cken_q, cken_d;
    logic                    grst_q, grst_d;
    logic                    dbg_q, dbg_d;
    logic                    wack_q, wack_d;
    logic                    dack_q, dack_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            cken_q  <= '0;
            grst_q  <= 1'b0;
            dbg_q   <= 1'b0;
            wack_q  <= 1'b0;
            dack_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            cken_q  <= cken_d;
            grst_q  <= grst_d;
            dbg_q   <= dbg_d;
            wack_q  <= wack_d;
            dack_q  <= dack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        cken_d  = cken_q;
        grst_d  = grst_q;
        dbg_d   = dbg_q;
        wack_d  = 1'b0;
        dack_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                slot_d = '0;
                if (por_done) state_d = S_CKEN_ON;
            end
            S_CKEN_ON: begin
                // The enable for a slot is taken on the first cycle of that
                // slot; the mask is only looked at then, so later mask
                // changes do not touch clusters whose slot has passed.
                if (cnt_q == '0 && cken_mask[slot_q]) cken_d[slot_q] = 1'b1;
                if (cnt_q == '0 && slot_q == SLOT_LAST) begin
                    // The final slot does not wait out its stagger; the
                    // reset hold window starts right away.
                    state_d = S_RST_HLD;
                    cnt_d   = '0;
                end else if (cnt_q == STAG_LAST) begin
                    slot_d = slot_q + SW'(1);
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RST_HLD, S_WARM: begin
                if (cnt_q == RST_LAST) begin
                    grst_d  = 1'b1;
                    dbg_d   = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                cnt_d = '0;
                // Warm reset has priority; a simultaneous debug request
                // stays pending and is seen again after WARM.
                if (warm_rst_req) begin
                    wack_d  = 1'b1;
                    grst_d  = 1'b0;
                    dbg_d   = 1'b0;
                    state_d = S_WARM;
                end else if (dbg_init_req) begin
                    dack_d  = 1'b1;
                    dbg_d   = 1'b0;
                    state_d = S_DBG;
                end
            end
            S_DBG: begin
                if (cnt_q == DBG_LAST) begin
                    dbg_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                slot_d  = '0;
            end
        endcase

        // Losing power-on-done anywhere outside IDLE abandons the sequence.
        if (state_q != S_IDLE && !por_done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            slot_d  = '0;
            cken_d  = '0;
            grst_d  = 1'b0;
            dbg_d   = 1'b0;
            wack_d  = 1'b0;
            dack_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_RUN);

`ifdef CTU_RST_SEQ_SCAN_EN
        // Scan freezes the whole sequencer in place; pulses are suppressed.
        if (se) begin
            state_d = state_q;
            cnt_d   = cnt_q;
            slot_d  = slot_q;
            cken_d  = cken_q;
            grst_d  = grst_q;
            dbg_d   = dbg_q;
            wack_d  = 1'b0;
            dack_d  = 1'b0;
            done_d  = 1'b0;
            busy_d  = busy_q;
        end
`endif
    end

`ifdef CTU_RST_SEQ_SCAN_EN
    assign cluster_cken = se ? {NUM_CLUSTERS{1'b1}} : cken_q;
`else
    assign cluster_cken = cken_q;
`endif
    assign grst_l       = grst_q;
    assign gdbginit_l   = dbg_q;
    assign warm_rst_ack = wack_q;
    assign dbg_init_ack = dack_q;
    assign rst_done     = done_q;
    assign seq_busy     = busy_q;

endmodule
